// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one combinational-read / edge-write data memory between
// the core load/store port (port 0) and a second master (port 1).
// One access is granted per cycle. Read data is registered and comes with a
// one-cycle rvalid strobe.
// Build option ARB_RR_EN: when defined, ties are resolved round-robin and
// ownership is capped at MAX_BURST grants under contention. When undefined,
// port 0 has fixed priority.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("dmem_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] p0_rdata_q, p1_rdata_q;
  logic          p0_rvalid_q, p1_rvalid_q;

  // Grants follow the current owner; the memory port sees only the granted master
  always_comb begin
    p0_gnt = (state_q == OWN0) & p0_req;
    p1_gnt = (state_q == OWN1) & p1_req;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (p0_gnt) begin
      mem_we = p0_we;
      mem_a  = p0_addr;
      mem_wd = p0_wdata;
    end else if (p1_gnt) begin
      mem_we = p1_we;
      mem_a  = p1_addr;
      mem_wd = p1_wdata;
    end
  end

  // Capture read data at the end of a granted read; rvalid strobes for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= p0_gnt & ~p0_we;
      p1_rvalid_q <= p1_gnt & ~p1_we;
      if (p0_gnt & ~p0_we) p0_rdata_q <= mem_rd;
      if (p1_gnt & ~p1_we) p1_rdata_q <= mem_rd;
    end
  end

  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

  // Owner register; reset drops ownership at once so no write can slip through
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef ARB_RR_EN
  // Counter is wide enough to hold MAX_BURST itself; it saturates there.
  localparam int CW = $clog2(MAX_BURST) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          burst_done;

  // Round-robin owner selection with a burst cap under contention
  always_comb begin
    burst_done = ({1'b0, cnt_q} + (CW+1)'(1)) >= (CW+1)'(MAX_BURST);
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (p0_req && p1_req) state_d = last_q ? OWN0 : OWN1;
        else if (p0_req)      state_d = OWN0;
        else if (p1_req)      state_d = OWN1;
        else                  state_d = IDLE;
      end
      OWN0: begin
        if (p0_req && p1_req) state_d = burst_done ? OWN1 : OWN0;
        else if (p0_req)      state_d = OWN0;
        else if (p1_req)      state_d = OWN1;
        else                  state_d = IDLE;
      end
      OWN1: begin
        if (p0_req && p1_req) state_d = burst_done ? OWN0 : OWN1;
        else if (p1_req)      state_d = OWN1;
        else if (p0_req)      state_d = OWN0;
        else                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else if ((p0_gnt || p1_gnt) && (cnt_q != CW'(MAX_BURST))) cnt_d = cnt_q + CW'(1);

    last_d = last_q;
    if (p0_gnt)      last_d = 1'b0;
    else if (p1_gnt) last_d = 1'b1;
  end

  // Burst length and last-served port; last starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: port 0 takes or keeps the memory whenever it asks
  always_comb begin
    state_d = IDLE;
    if (p0_req)      state_d = OWN0;
    else if (p1_req) state_d = OWN1;
  end
`endif

endmodule
